// File: rtl/memory_access.sv
// memory_access -- MEM stage of the 5-stage MIPS pipeline.
//
// Takes the EX/MEM latch and does four jobs:
//   - performs byte/half/word loads and stores, signed or unsigned, on a
//     word-organised data RAM
//   - resolves the branch decision for fetch
//   - registers the MEM/WB latch
//   - sources the forwarding operands used by the execute stage
//
// Ports:
//   clk                 clock; all state updates on posedge
//   reset               synchronous active-low reset
//   in_pc_branch        branch target          -> out_pc_branch (combinational)
//   in_alu              ALU result, which is also the byte address
//   in_zero_flag        ALU zero flag
//   in_reg2             store data
//   in_write_reg        destination register
//   memory_bus          [8] beq, [7] bne, [6] mem_read, [5] mem_write,
//                       [4] load_unsigned, [3:2] size (00 byte, 01 half,
//                       1x word), [1:0] ignored
//   writeBack_bus       [1] reg_write, [0] mem_to_reg
//   out_pc_src          branch taken (combinational)
//   out_mem_forw        in_alu forwarded to EX (combinational)
//   register_write_3_4  writeBack_bus[1] forwarded to EX (combinational)
//   rd_3_4              in_write_reg forwarded to EX (combinational)
//   out_mem_data        load result, aligned and extended; 1-cycle latency
//   out_alu             registered in_alu
//   out_write_reg       registered in_write_reg
//   writeBack_bus_out   registered writeBack_bus
//   out_misaligned      registered misaligned-access flag
//
// Optional feature, enabled by the macro DATA_MEM_DEBUG_EN:
//   debug_addr (in)     word address of a side read port
//   debug_data (out)    registered RAM word at debug_addr; resets to 0
module memory_access #(
    parameter int len         = 32,
    parameter int NB          = 5,
    parameter int len_mem_bus = 9,
    parameter int len_wb_bus  = 2,
    parameter int depth       = 256,
    parameter int NB_ADDR     = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [len-1:0]        in_pc_branch,
    input  logic [len-1:0]        in_alu,
    input  logic                  in_zero_flag,
    input  logic [len-1:0]        in_reg2,
    input  logic [NB-1:0]         in_write_reg,
    input  logic [len_mem_bus-1:0] memory_bus,
    input  logic [len_wb_bus-1:0] writeBack_bus,
    output logic [len-1:0]        out_pc_branch,
    output logic                  out_pc_src,
    output logic [len-1:0]        out_mem_forw,
    output logic                  register_write_3_4,
    output logic [NB-1:0]         rd_3_4,
    output logic [len-1:0]        out_mem_data,
    output logic [len-1:0]        out_alu,
    output logic [NB-1:0]         out_write_reg,
    output logic [len_wb_bus-1:0] writeBack_bus_out,
    output logic                  out_misaligned
`ifdef DATA_MEM_DEBUG_EN
    ,
    input  logic [NB_ADDR-1:0]    debug_addr,
    output logic [len-1:0]        debug_data
`endif
);

    localparam int LANES = len / 8;

    // Selects the addressed lane of the raw word and extends it to len bits.
    // size 00 = byte, 01 = half, anything else = word (returned unchanged).
    function automatic logic [len-1:0] extend_load(
        input logic [len-1:0] raw,
        input logic [1:0]     lane,
        input logic [1:0]     size,
        input logic           uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [len-1:0] result;
        case (lane)
            2'b00:   b = raw[7:0];
            2'b01:   b = raw[15:8];
            2'b10:   b = raw[23:16];
            2'b11:   b = raw[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? raw[31:16] : raw[15:0];
        case (size)
            2'b00:   result = {{(len-8){~uns & b[7]}}, b};
            2'b01:   result = {{(len-16){~uns & h[15]}}, h};
            default: result = raw;
        endcase
        return result;
    endfunction

    logic                  beq_s;
    logic                  bne_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic                  load_unsigned_s;
    logic [1:0]            size_s;
    logic [NB_ADDR-1:0]    word_addr_s;
    logic                  misaligned_s;
    logic                  store_en_s;
    logic                  load_en_s;
    logic [LANES-1:0]      byte_en_s;
    logic [len-1:0]        store_data_s;
    logic                  unused_s;

    logic [len-1:0]        mem_r [depth];
    logic [len-1:0]        raw_r;
    logic [1:0]            lane_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic                  load_valid_r;

    assign beq_s           = memory_bus[8];
    assign bne_s           = memory_bus[7];
    assign mem_read_s      = memory_bus[6];
    assign mem_write_s     = memory_bus[5];
    assign load_unsigned_s = memory_bus[4];
    assign size_s          = memory_bus[3:2];

    // Upper address bits wrap modulo depth; reserved control bits carry no meaning.
    assign word_addr_s = in_alu[NB_ADDR+1:2];
    assign unused_s    = ^{memory_bus[1:0], in_alu[len-1:NB_ADDR+2]};

    // Pure combinational outputs towards fetch and execute.
    assign out_pc_branch      = in_pc_branch;
    assign out_pc_src         = (beq_s & in_zero_flag) | (bne_s & ~in_zero_flag);
    assign out_mem_forw       = in_alu;
    assign register_write_3_4 = writeBack_bus[1];
    assign rd_3_4             = in_write_reg;

    // Access decode: alignment check, lane enables and replicated store data.
    always_comb begin
        misaligned_s = 1'b0;
        byte_en_s    = 4'b0000;
        store_data_s = in_reg2;
        case (size_s)
            2'b00: begin
                byte_en_s    = 4'b0001 << in_alu[1:0];
                store_data_s = {LANES{in_reg2[7:0]}};
            end
            2'b01: begin
                misaligned_s = in_alu[0];
                byte_en_s    = in_alu[1] ? 4'b1100 : 4'b0011;
                store_data_s = {(LANES/2){in_reg2[15:0]}};
            end
            default: begin
                misaligned_s = (in_alu[1:0] != 2'b00);
                byte_en_s    = 4'b1111;
                store_data_s = in_reg2;
            end
        endcase
        // Only a real access can be misaligned; bubbles never flag.
        if (mem_read_s | mem_write_s) begin
            misaligned_s = misaligned_s;
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // A store wins over a simultaneous read, and reset suppresses any store.
    assign store_en_s = reset & mem_write_s & ~misaligned_s;
    assign load_en_s  = mem_read_s & ~mem_write_s & ~misaligned_s;

    // Data RAM: byte-lane writes and a synchronous read into the raw-word register.
    always_ff @(posedge clk) begin
        if (store_en_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[word_addr_s][8*i +: 8] <= store_data_s[8*i +: 8];
                end
            end
        end
        raw_r <= mem_r[word_addr_s];
    end

    // MEM/WB latch plus the lane/size/sign needed to shape the load result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_alu           <= '0;
            out_write_reg     <= '0;
            writeBack_bus_out <= '0;
            out_misaligned    <= 1'b0;
            lane_r            <= 2'b00;
            size_r            <= 2'b00;
            uns_r             <= 1'b0;
            load_valid_r      <= 1'b0;
        end else begin
            out_alu           <= in_alu;
            out_write_reg     <= in_write_reg;
            writeBack_bus_out <= writeBack_bus;
            out_misaligned    <= misaligned_s;
            lane_r            <= in_alu[1:0];
            size_r            <= size_s;
            uns_r             <= load_unsigned_s;
            load_valid_r      <= load_en_s;
        end
    end

    // Non-load cycles (stores, bubbles, misaligned loads) read back as zero.
    always_comb begin
        if (load_valid_r) begin
            out_mem_data = extend_load(raw_r, lane_r, size_r, uns_r);
        end else begin
            out_mem_data = '0;
        end
    end

`ifdef DATA_MEM_DEBUG_EN
    // Side read port for inspecting RAM contents without disturbing the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            debug_data <= '0;
        end else begin
            debug_data <= mem_r[debug_addr];
        end
    end
`else
    // No debug read port in this build.
`endif

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic        clk;
    logic        reset;
    logic [31:0] in_pc_branch;
    logic [31:0] in_alu;
    logic        in_zero_flag;
    logic [31:0] in_reg2;
    logic [4:0]  in_write_reg;
    logic [8:0]  memory_bus;
    logic [1:0]  writeBack_bus;
    logic [31:0] out_pc_branch;
    logic        out_pc_src;
    logic [31:0] out_mem_forw;
    logic        register_write_3_4;
    logic [4:0]  rd_3_4;
    logic [31:0] out_mem_data;
    logic [31:0] out_alu;
    logic [4:0]  out_write_reg;
    logic [1:0]  writeBack_bus_out;
    logic        out_misaligned;

    int total = 0;
    int bad   = 0;

    memory_access dut (
        .clk                (clk),
        .reset              (reset),
        .in_pc_branch       (in_pc_branch),
        .in_alu             (in_alu),
        .in_zero_flag       (in_zero_flag),
        .in_reg2            (in_reg2),
        .in_write_reg       (in_write_reg),
        .memory_bus         (memory_bus),
        .writeBack_bus      (writeBack_bus),
        .out_pc_branch      (out_pc_branch),
        .out_pc_src         (out_pc_src),
        .out_mem_forw       (out_mem_forw),
        .register_write_3_4 (register_write_3_4),
        .rd_3_4             (rd_3_4),
        .out_mem_data       (out_mem_data),
        .out_alu            (out_alu),
        .out_write_reg      (out_write_reg),
        .writeBack_bus_out  (writeBack_bus_out),
        .out_misaligned     (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one MEM-stage access (no branch bits).
    task automatic drive(input logic mr, input logic mw, input logic uns,
                         input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] wb,
                         input logic [4:0] rd);
        memory_bus    = {2'b00, mr, mw, uns, sz, 2'b00};
        in_alu        = addr;
        in_reg2       = data;
        writeBack_bus = wb;
        in_write_reg  = rd;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0044, 32'h0, 2'b11, 5'd3);
        tick();
        tick();
        total++; if (out_alu !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=%h", out_alu, 32'h0); end
        total++; if (out_write_reg !== 5'd0) begin bad++; $display("FAIL reset_rd got=%h exp=%h", out_write_reg, 5'd0); end
        total++; if (writeBack_bus_out !== 2'b00) begin bad++; $display("FAIL reset_wb got=%b exp=%b", writeBack_bus_out, 2'b00); end
        total++; if (out_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=%b", out_misaligned, 1'b0); end
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", out_mem_data, 32'h0); end
        reset = 1'b1;
    endtask

    task automatic test_word();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 5'd0);
        tick();
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL store_data0 got=%h exp=%h", out_mem_data, 32'h0); end
        total++; if (out_alu !== 32'h10) begin bad++; $display("FAIL store_alu got=%h exp=%h", out_alu, 32'h10); end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0010, 32'h0, 2'b11, 5'd7);
        tick();
        total++; if (out_mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_word got=%h exp=%h", out_mem_data, 32'hDEAD_BEEF); end
        total++; if (out_write_reg !== 5'd7) begin bad++; $display("FAIL load_rd got=%h exp=%h", out_write_reg, 5'd7); end
        total++; if (writeBack_bus_out !== 2'b11) begin bad++; $display("FAIL load_wb got=%b exp=%b", writeBack_bus_out, 2'b11); end
    endtask

    task automatic test_byte();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0011, 32'h0000_00A5, 2'b00, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0011, 32'h0, 2'b11, 5'd1);
        tick();
        total++; if (out_mem_data !== 32'hFFFF_FFA5) begin bad++; $display("FAIL lb got=%h exp=%h", out_mem_data, 32'hFFFF_FFA5); end
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0011, 32'h0, 2'b11, 5'd1);
        tick();
        total++; if (out_mem_data !== 32'h0000_00A5) begin bad++; $display("FAIL lbu got=%h exp=%h", out_mem_data, 32'h0000_00A5); end
        drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 2'b11, 5'd1);
        tick();
        total++; if (out_mem_data !== 32'hDEAD_A5EF) begin bad++; $display("FAIL byte_merge got=%h exp=%h", out_mem_data, 32'hDEAD_A5EF); end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0013, 32'h0, 2'b11, 5'd1);
        tick();
        total++; if (out_mem_data !== 32'hFFFF_FFDE) begin bad++; $display("FAIL lb_lane3 got=%h exp=%h", out_mem_data, 32'hFFFF_FFDE); end
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'h0, 2'b11, 5'd1);
        tick();
        total++; if (out_mem_data !== 32'h0000_00EF) begin bad++; $display("FAIL lbu_lane0 got=%h exp=%h", out_mem_data, 32'h0000_00EF); end
    endtask

    task automatic test_half();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h8001_0000, 2'b00, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0012, 32'h0, 2'b11, 5'd2);
        tick();
        total++; if (out_mem_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh got=%h exp=%h", out_mem_data, 32'hFFFF_8001); end
        drive(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0012, 32'h0, 2'b11, 5'd2);
        tick();
        total++; if (out_mem_data !== 32'h0000_8001) begin bad++; $display("FAIL lhu got=%h exp=%h", out_mem_data, 32'h0000_8001); end
        drive(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h1234_F00D, 2'b00, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0010, 32'h0, 2'b11, 5'd2);
        tick();
        total++; if (out_mem_data !== 32'h8001_F00D) begin bad++; $display("FAIL sh_merge got=%h exp=%h", out_mem_data, 32'h8001_F00D); end
        drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0010, 32'h0, 2'b11, 5'd2);
        tick();
        total++; if (out_mem_data !== 32'hFFFF_F00D) begin bad++; $display("FAIL lh_low got=%h exp=%h", out_mem_data, 32'hFFFF_F00D); end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'hCAFE_F00D, 2'b00, 5'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0021, 32'h1234_5678, 2'b00, 5'd0);
        tick();
        total++; if (out_misaligned !== 1'b1) begin bad++; $display("FAIL mis_store got=%b exp=%b", out_misaligned, 1'b1); end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0020, 32'h0, 2'b11, 5'd4);
        tick();
        total++; if (out_mem_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_unchanged got=%h exp=%h", out_mem_data, 32'hCAFE_F00D); end
        total++; if (out_misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=%b", out_misaligned, 1'b0); end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0022, 32'h0, 2'b11, 5'd4);
        tick();
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL mis_load_data got=%h exp=%h", out_mem_data, 32'h0); end
        total++; if (out_misaligned !== 1'b1) begin bad++; $display("FAIL mis_load_flag got=%b exp=%b", out_misaligned, 1'b1); end
        drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0023, 32'h0, 2'b11, 5'd4);
        tick();
        total++; if (out_misaligned !== 1'b1) begin bad++; $display("FAIL mis_half got=%b exp=%b", out_misaligned, 1'b1); end
        drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0022, 32'h0, 2'b11, 5'd4);
        tick();
        total++; if (out_mem_data !== 32'hFFFF_CAFE) begin bad++; $display("FAIL half_hi got=%h exp=%h", out_mem_data, 32'hFFFF_CAFE); end
        total++; if (out_misaligned !== 1'b0) begin bad++; $display("FAIL half_hi_flag got=%b exp=%b", out_misaligned, 1'b0); end
    endtask

    task automatic test_branch();
        in_pc_branch  = 32'h0040_0040;
        in_alu        = 32'h0000_1234;
        in_write_reg  = 5'd19;
        writeBack_bus = 2'b10;
        memory_bus = 9'b1_0000_0000; in_zero_flag = 1'b1; #1;
        total++; if (out_pc_src !== 1'b1) begin bad++; $display("FAIL beq_z1 got=%b exp=%b", out_pc_src, 1'b1); end
        memory_bus = 9'b1_0000_0000; in_zero_flag = 1'b0; #1;
        total++; if (out_pc_src !== 1'b0) begin bad++; $display("FAIL beq_z0 got=%b exp=%b", out_pc_src, 1'b0); end
        memory_bus = 9'b0_1000_0000; in_zero_flag = 1'b1; #1;
        total++; if (out_pc_src !== 1'b0) begin bad++; $display("FAIL bne_z1 got=%b exp=%b", out_pc_src, 1'b0); end
        memory_bus = 9'b0_1000_0000; in_zero_flag = 1'b0; #1;
        total++; if (out_pc_src !== 1'b1) begin bad++; $display("FAIL bne_z0 got=%b exp=%b", out_pc_src, 1'b1); end
        total++; if (out_pc_branch !== 32'h0040_0040) begin bad++; $display("FAIL pc_branch got=%h exp=%h", out_pc_branch, 32'h0040_0040); end
        total++; if (out_mem_forw !== 32'h0000_1234) begin bad++; $display("FAIL mem_forw got=%h exp=%h", out_mem_forw, 32'h0000_1234); end
        total++; if (rd_3_4 !== 5'd19) begin bad++; $display("FAIL rd_3_4 got=%h exp=%h", rd_3_4, 5'd19); end
        total++; if (register_write_3_4 !== 1'b1) begin bad++; $display("FAIL regwr_3_4 got=%b exp=%b", register_write_3_4, 1'b1); end
        in_zero_flag = 1'b0;
    endtask

    task automatic test_read_write_bubble();
        drive(1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0040, 32'h55AA_55AA, 2'b11, 5'd6);
        tick();
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL rw_data got=%h exp=%h", out_mem_data, 32'h0); end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0040, 32'h0, 2'b11, 5'd6);
        tick();
        total++; if (out_mem_data !== 32'h55AA_55AA) begin bad++; $display("FAIL rw_stored got=%h exp=%h", out_mem_data, 32'h55AA_55AA); end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 5'd0);
        tick();
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL bubble_data got=%h exp=%h", out_mem_data, 32'h0); end
        total++; if (writeBack_bus_out !== 2'b00) begin bad++; $display("FAIL bubble_wb got=%b exp=%b", writeBack_bus_out, 2'b00); end
        total++; if (out_write_reg !== 5'd0) begin bad++; $display("FAIL bubble_rd got=%h exp=%h", out_write_reg, 5'd0); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0030, 32'h1111_2222, 2'b00, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0030, 32'h0, 2'b11, 5'd8);
        tick();
        total++; if (out_mem_data !== 32'h1111_2222) begin bad++; $display("FAIL pre_reset got=%h exp=%h", out_mem_data, 32'h1111_2222); end
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0030, 32'h9999_9999, 2'b11, 5'd9);
        tick();
        total++; if (out_mem_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h exp=%h", out_mem_data, 32'h0); end
        total++; if (out_alu !== 32'h0) begin bad++; $display("FAIL mid_alu got=%h exp=%h", out_alu, 32'h0); end
        total++; if (out_write_reg !== 5'd0) begin bad++; $display("FAIL mid_rd got=%h exp=%h", out_write_reg, 5'd0); end
        total++; if (writeBack_bus_out !== 2'b00) begin bad++; $display("FAIL mid_wb got=%b exp=%b", writeBack_bus_out, 2'b00); end
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0030, 32'h0, 2'b11, 5'd8);
        tick();
        total++; if (out_mem_data !== 32'h1111_2222) begin bad++; $display("FAIL mid_suppressed got=%h exp=%h", out_mem_data, 32'h1111_2222); end
    endtask

    initial begin
        reset        = 1'b0;
        in_pc_branch = 32'h0;
        in_zero_flag = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 5'd0);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_branch();
        test_read_write_bubble();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
